// File: rtl/move_pkg.sv
// -----------------------------------------------------------------------------
// move_pkg
// Shared definitions for the move sequencer and its sensor debouncer:
//   - sequencer state encodings (legacy-compatible 3-bit constants)
//   - motor H-bridge codes and navigation FSM movement_sel codes
//   - command decode helpers (motor drive, duration class, legality)
// -----------------------------------------------------------------------------
package move_pkg;

  // Sequencer states
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SAMPLE = 3'd1;
  localparam logic [2:0] ST_DECIDE = 3'd2;
  localparam logic [2:0] ST_MOVE   = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  // Motor H-bridge enables
  localparam logic [1:0] MOT_OFF = 2'b00;
  localparam logic [1:0] MOT_FWD = 2'b01;
  localparam logic [1:0] MOT_REV = 2'b10;

  // movement_sel codes from the navigation FSM
  localparam logic [3:0] SEL_HOLD  = 4'd0;
  localparam logic [3:0] SEL_FWD   = 4'd1;
  localparam logic [3:0] SEL_LEFT  = 4'd2;
  localparam logic [3:0] SEL_RIGHT = 4'd4;

  // Duration class of a manoeuvre; the sequencer maps it onto its tick params
  typedef enum logic [1:0] {
    DUR_HOLD = 2'd0,
    DUR_MOVE = 2'd1,
    DUR_TURN = 2'd2
  } dur_e;

  // Motor drive pair for one command
  typedef struct packed {
    logic [1:0] mot_l;
    logic [1:0] mot_r;
  } motor_pair_t;

  // Motor drive for a (ctl, sel) pair; anything not a recognised move holds.
  function automatic motor_pair_t cmd_motors(input logic [1:0] ctl, input logic [3:0] sel);
    motor_pair_t m;
    m.mot_l = MOT_OFF;
    m.mot_r = MOT_OFF;
    if (ctl == 2'd0) begin
      m.mot_l = MOT_OFF;
      m.mot_r = MOT_OFF;
    end else begin
      case (sel)
        SEL_FWD:   begin m.mot_l = MOT_FWD; m.mot_r = MOT_FWD; end
        SEL_LEFT:  begin m.mot_l = MOT_REV; m.mot_r = MOT_FWD; end
        SEL_RIGHT: begin m.mot_l = MOT_FWD; m.mot_r = MOT_REV; end
        default:   begin m.mot_l = MOT_OFF; m.mot_r = MOT_OFF; end
      endcase
    end
    return m;
  endfunction

  // Duration class for a (ctl, sel) pair.
  function automatic dur_e cmd_duration(input logic [1:0] ctl, input logic [3:0] sel);
    dur_e d;
    d = DUR_HOLD;
    if (ctl == 2'd0) begin
      d = DUR_HOLD;
    end else begin
      case (sel)
        SEL_FWD:   d = DUR_MOVE;
        SEL_LEFT:  d = DUR_TURN;
        SEL_RIGHT: d = DUR_TURN;
        default:   d = DUR_HOLD;
      endcase
    end
    return d;
  endfunction

  // A command is illegal only when the FSM is active (ctl != 0) and
  // movement_sel is not one of the four known codes.
  function automatic logic cmd_illegal(input logic [1:0] ctl, input logic [3:0] sel);
    logic bad;
    bad = 1'b0;
    if (ctl == 2'd0) begin
      bad = 1'b0;
    end else begin
      case (sel)
        SEL_HOLD, SEL_FWD, SEL_LEFT, SEL_RIGHT: bad = 1'b0;
        default:                               bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/move_sequencer_sensor_debounce.sv
// -----------------------------------------------------------------------------
// sensor_debounce
// Two-flop synchroniser followed by a per-bit consecutive-sample debouncer.
// A stable bit flips only after DEBOUNCE consecutive synchronised samples that
// all differ from its current value; any agreeing sample restarts the count.
// Latency from a clean raw edge to stable_o: 2 + DEBOUNCE cycles.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   raw_i     raw sensor bits, asynchronous to clk
//   stable_o  debounced sensor bits (registered)
// -----------------------------------------------------------------------------
module sensor_debounce
  import move_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int W        = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] stable_o
);

  localparam int DW = $clog2(DEBOUNCE) + 1;
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE - 1);

  logic [W-1:0]  sync1_q;
  logic [W-1:0]  sync2_q;
  logic [W-1:0]  stable_q;
  logic [W-1:0]  stable_d;
  logic [DW-1:0] cnt_q [W];
  logic [DW-1:0] cnt_d [W];

  // Per-bit debounce: count disagreeing samples, commit on the last one
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < W; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        cnt_d[i]    = '0;
        stable_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  // Synchroniser, debounce counters and stable bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < W; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < W; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/move_sequencer.sv
// -----------------------------------------------------------------------------
// move_sequencer
// Time-base and sequencing controller for the wall-following navigation FSM.
// Debounces the wall sensors, samples the FSM's Mealy outputs once per move,
// drives the motor H-bridge enables for a timed duration, and pulses nav_step
// once per manoeuvre so the FSM advances exactly once per move.
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   enable         run request; low forces IDLE
//   sensor_raw     raw wall sensors (async)
//   state_control  navigation FSM Mealy output (ctl)
//   movement_sel   navigation FSM Mealy output (cmd)
//   sensor_stable  debounced sensors to the navigation FSM
//   nav_step       one-cycle clock enable for the FSM state register
//   motor_l/_r     motor enables: 01 fwd, 10 rev, 00 off
//   busy           high in any state except IDLE
//   move_count     completed manoeuvres, saturating
//   err            sticky illegal-command flag
// -----------------------------------------------------------------------------
module move_sequencer
  import move_pkg::*;
#(
  parameter int MOVE_TICKS = 1000,
  parameter int TURN_TICKS = 500,
  parameter int HOLD_TICKS = 8,
  parameter int DEBOUNCE   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  sensor_raw,
  input  logic [1:0]  state_control,
  input  logic [3:0]  movement_sel,
  output logic [3:0]  sensor_stable,
  output logic        nav_step,
  output logic [1:0]  motor_l,
  output logic [1:0]  motor_r,
  output logic        busy,
  output logic [15:0] move_count,
  output logic        err
);

  localparam int SAMPLE_TICKS = DEBOUNCE + 2;
  localparam int MAX_MT = (MOVE_TICKS > TURN_TICKS) ? MOVE_TICKS : TURN_TICKS;
  localparam int MAX_HS = (HOLD_TICKS > SAMPLE_TICKS) ? HOLD_TICKS : SAMPLE_TICKS;
  localparam int MAX_T  = (MAX_MT > MAX_HS) ? MAX_MT : MAX_HS;
  localparam int CW     = $clog2(MAX_T) + 1;

  // Counters are loaded with N-1 and the state exits on zero, giving N cycles
  localparam logic [CW-1:0] LD_MOVE   = CW'(MOVE_TICKS - 1);
  localparam logic [CW-1:0] LD_TURN   = CW'(TURN_TICKS - 1);
  localparam logic [CW-1:0] LD_HOLD   = CW'(HOLD_TICKS - 1);
  localparam logic [CW-1:0] LD_SAMPLE = CW'(SAMPLE_TICKS - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    ctl_q, ctl_d;
  logic [3:0]    sel_q, sel_d;
  logic          err_q, err_d;
  logic [15:0]   count_q, count_d;
  logic          nav_q, nav_d;
  logic [1:0]    mot_l_q, mot_l_d;
  logic [1:0]    mot_r_q, mot_r_d;

  motor_pair_t   new_mot_s;
  motor_pair_t   cur_mot_s;
  dur_e          new_dur_s;
  logic          new_bad_s;
  logic [CW-1:0] decide_load_s;

  // Debounced sensors feed the navigation FSM directly
  sensor_debounce #(
    .DEBOUNCE (DEBOUNCE),
    .W        (4)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (sensor_raw),
    .stable_o (sensor_stable)
  );

  // new_* decode the live FSM outputs (used in DECIDE), cur_* the latched ones
  assign new_mot_s = cmd_motors(state_control, movement_sel);
  assign new_dur_s = cmd_duration(state_control, movement_sel);
  assign new_bad_s = cmd_illegal(state_control, movement_sel);
  assign cur_mot_s = cmd_motors(ctl_q, sel_q);

  // Map the duration class of the new command onto its counter load value
  always_comb begin
    decide_load_s = LD_HOLD;
    case (new_dur_s)
      DUR_MOVE: decide_load_s = LD_MOVE;
      DUR_TURN: decide_load_s = LD_TURN;
      DUR_HOLD: decide_load_s = LD_HOLD;
      default:  decide_load_s = LD_HOLD;
    endcase
  end

  // Sequencer next-state, counter and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl_d   = ctl_q;
    sel_d   = sel_q;
    err_d   = err_q;
    count_d = count_q;
    nav_d   = 1'b0;
    mot_l_d = MOT_OFF;
    mot_r_d = MOT_OFF;
    if (!enable) begin
      // Abort from anywhere: motors already default off, no step, no count
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SAMPLE;
          cnt_d   = LD_SAMPLE;
        end
        ST_SAMPLE: begin
          if (cnt_q == '0) begin
            // nav_step is registered, so it is high exactly during DECIDE
            state_d = ST_DECIDE;
            nav_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_DECIDE: begin
          ctl_d   = state_control;
          sel_d   = movement_sel;
          err_d   = err_q | new_bad_s;
          mot_l_d = new_mot_s.mot_l;
          mot_r_d = new_mot_s.mot_r;
          cnt_d   = decide_load_s;
          state_d = ST_MOVE;
        end
        ST_MOVE: begin
          if (cnt_q == '0) begin
            state_d = ST_SETTLE;
            cnt_d   = LD_HOLD;
            count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          end else begin
            cnt_d   = cnt_q - CW'(1);
            mot_l_d = cur_mot_s.mot_l;
            mot_r_d = cur_mot_s.mot_r;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = ST_SAMPLE;
            cnt_d   = LD_SAMPLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctl_q   <= 2'd0;
      sel_q   <= 4'd0;
      err_q   <= 1'b0;
      count_q <= 16'd0;
      nav_q   <= 1'b0;
      mot_l_q <= MOT_OFF;
      mot_r_q <= MOT_OFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      count_q <= count_d;
      nav_q   <= nav_d;
      mot_l_q <= mot_l_d;
      mot_r_q <= mot_r_d;
    end
  end

  assign nav_step   = nav_q;
  assign motor_l    = mot_l_q;
  assign motor_r    = mot_r_q;
  assign move_count = count_q;
  assign err        = err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_move_sequencer.sv
// -----------------------------------------------------------------------------
// tb_move_sequencer
// Self-checking bench for move_sequencer with MOVE=10, TURN=6, HOLD=3,
// DEBOUNCE=4. Expected manoeuvres are queued when the command is driven and
// popped when the DUT issues nav_step.
// -----------------------------------------------------------------------------
module tb_move_sequencer;

  localparam int MOVE_T = 10;
  localparam int TURN_T = 6;
  localparam int HOLD_T = 3;
  localparam int DEB    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  sensor_raw;
  logic [1:0]  state_control;
  logic [3:0]  movement_sel;
  logic [3:0]  sensor_stable;
  logic        nav_step;
  logic [1:0]  motor_l;
  logic [1:0]  motor_r;
  logic        busy;
  logic [15:0] move_count;
  logic        err;

  always #5 clk = ~clk;

  move_sequencer #(
    .MOVE_TICKS (MOVE_T),
    .TURN_TICKS (TURN_T),
    .HOLD_TICKS (HOLD_T),
    .DEBOUNCE   (DEB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .sensor_raw    (sensor_raw),
    .state_control (state_control),
    .movement_sel  (movement_sel),
    .sensor_stable (sensor_stable),
    .nav_step      (nav_step),
    .motor_l       (motor_l),
    .motor_r       (motor_r),
    .busy          (busy),
    .move_count    (move_count),
    .err           (err)
  );

  typedef struct {
    logic [1:0]  ml;
    logic [1:0]  mr;
    int          dur;
    logic [15:0] cnt;
    logic        er;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_count = 16'd0;
  logic        exp_err = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until nav_step is seen; lat = ticks taken, -1 if bound expired
  task automatic wait_nav(input int bound, output int lat);
    lat = -1;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (nav_step === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; sensor_raw = 4'd0; state_control = 2'd0; movement_sel = 4'd0;
    tick(); tick();
    n_vec++;
    if ({motor_l, motor_r, nav_step, busy, err} !== 7'd0 || move_count !== 16'd0 || sensor_stable !== 4'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got ml=%b mr=%b nav=%b busy=%b err=%b cnt=%0d ss=%b want all zero",
               motor_l, motor_r, nav_step, busy, err, move_count, sensor_stable);
    end
    #2 rst = 1'b1;
    tick(); tick();
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_forward();
    exp_t e;
    int   lat;
    movement_sel = 4'd1; state_control = 2'd1; enable = 1'b1;
    exp_count = exp_count + 16'd1;
    sb.push_back('{2'b01, 2'b01, MOVE_T, exp_count, exp_err});
    tick();
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL fwd_busy_sample: got %b want 1", busy); end
    wait_nav(20, lat);
    n_vec++;
    if (lat != DEB + 2) begin n_err++; $display("FAIL fwd_nav_latency: got %0d want %0d", lat, DEB + 2); end
    e = sb.pop_front();
    for (int t = 1; t <= e.dur + 1; t++) begin
      logic [1:0] wl, wr;
      wl = (t <= e.dur) ? e.ml : 2'b00;
      wr = (t <= e.dur) ? e.mr : 2'b00;
      tick();
      n_vec++;
      if (motor_l !== wl || motor_r !== wr || nav_step !== 1'b0) begin
        n_err++;
        $display("FAIL fwd_motor t=%0d: got %b/%b nav=%b want %b/%b nav=0", t, motor_l, motor_r, nav_step, wl, wr);
      end
    end
    n_vec++;
    if (move_count !== e.cnt || err !== e.er) begin
      n_err++;
      $display("FAIL fwd_count: got cnt=%0d err=%b want cnt=%0d err=%b", move_count, err, e.cnt, e.er);
    end
    for (int t = 0; t < HOLD_T - 1; t++) begin
      tick();
      n_vec++;
      if (motor_l !== 2'b00 || motor_r !== 2'b00 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL fwd_settle: got %b/%b busy=%b want 00/00 busy=1", motor_l, motor_r, busy);
      end
    end
    enable = 1'b0;
    tick();
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL fwd_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_debounce();
    int lat;
    enable = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sensor_raw = (c % 2 == 0) ? 4'b0001 : 4'b0000;
      for (int k = 0; k < 2; k++) begin
        tick();
        n_vec++;
        if (sensor_stable !== 4'b0000) begin
          n_err++;
          $display("FAIL deb_toggle c=%0d: got %b want 0000", c, sensor_stable);
        end
      end
    end
    sensor_raw = 4'b0001;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (sensor_stable[0] === 1'b1) begin lat = i; break; end
    end
    n_vec++;
    if (lat != DEB + 2 || sensor_stable !== 4'b0001) begin
      n_err++;
      $display("FAIL deb_rise: got latency %0d stable %b want %0d 0001", lat, sensor_stable, DEB + 2);
    end
    sensor_raw = 4'b0000;
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_turn_ignore();
    exp_t e;
    int   lat;
    movement_sel = 4'd4; state_control = 2'd1; enable = 1'b1;
    exp_count = exp_count + 16'd1;
    sb.push_back('{2'b01, 2'b10, TURN_T, exp_count, exp_err});
    wait_nav(20, lat);
    n_vec++;
    if (lat != DEB + 3) begin n_err++; $display("FAIL turn_nav_latency: got %0d want %0d", lat, DEB + 3); end
    e = sb.pop_front();
    for (int t = 1; t <= e.dur + 1; t++) begin
      logic [1:0] wl, wr;
      wl = (t <= e.dur) ? e.ml : 2'b00;
      wr = (t <= e.dur) ? e.mr : 2'b00;
      if (t == 2) movement_sel = 4'd2;
      tick();
      n_vec++;
      if (motor_l !== wl || motor_r !== wr || nav_step !== 1'b0) begin
        n_err++;
        $display("FAIL turn_motor t=%0d: got %b/%b nav=%b want %b/%b nav=0", t, motor_l, motor_r, nav_step, wl, wr);
      end
    end
    n_vec++;
    if (move_count !== e.cnt) begin
      n_err++;
      $display("FAIL turn_count: got %0d want %0d", move_count, e.cnt);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_illegal_back_to_back();
    exp_t e;
    int   lat;
    movement_sel = 4'd3; state_control = 2'd1; enable = 1'b1;
    exp_count = exp_count + 16'd1;
    exp_err = 1'b1;
    sb.push_back('{2'b00, 2'b00, HOLD_T, exp_count, exp_err});
    wait_nav(20, lat);
    e = sb.pop_front();
    for (int t = 1; t <= e.dur + 1; t++) begin
      tick();
      n_vec++;
      if (motor_l !== 2'b00 || motor_r !== 2'b00 || nav_step !== 1'b0) begin
        n_err++;
        $display("FAIL illegal_motor t=%0d: got %b/%b nav=%b want 00/00 nav=0", t, motor_l, motor_r, nav_step);
      end
    end
    n_vec++;
    if (move_count !== e.cnt || err !== e.er) begin
      n_err++;
      $display("FAIL illegal_err: got cnt=%0d err=%b want cnt=%0d err=%b", move_count, err, e.cnt, e.er);
    end
    // Next manoeuvre follows straight on: remaining SETTLE, then SAMPLE
    movement_sel = 4'd1;
    exp_count = exp_count + 16'd1;
    sb.push_back('{2'b01, 2'b01, MOVE_T, exp_count, exp_err});
    wait_nav(30, lat);
    n_vec++;
    if (lat != HOLD_T + DEB + 2) begin
      n_err++;
      $display("FAIL b2b_nav_latency: got %0d want %0d", lat, HOLD_T + DEB + 2);
    end
    e = sb.pop_front();
    for (int t = 1; t <= e.dur + 1; t++) begin
      logic [1:0] wl, wr;
      wl = (t <= e.dur) ? e.ml : 2'b00;
      wr = (t <= e.dur) ? e.mr : 2'b00;
      tick();
      n_vec++;
      if (motor_l !== wl || motor_r !== wr) begin
        n_err++;
        $display("FAIL b2b_motor t=%0d: got %b/%b want %b/%b", t, motor_l, motor_r, wl, wr);
      end
    end
    n_vec++;
    if (move_count !== e.cnt || err !== e.er) begin
      n_err++;
      $display("FAIL b2b_err_sticky: got cnt=%0d err=%b want cnt=%0d err=%b", move_count, err, e.cnt, e.er);
    end
    enable = 1'b0;
    tick();
  endtask

  task automatic test_enable_drop();
    int lat;
    movement_sel = 4'd1; state_control = 2'd1; enable = 1'b1;
    wait_nav(20, lat);
    for (int t = 1; t <= 5; t++) begin
      tick();
      n_vec++;
      if (motor_l !== 2'b01 || motor_r !== 2'b01) begin
        n_err++;
        $display("FAIL drop_premove t=%0d: got %b/%b want 01/01", t, motor_l, motor_r);
      end
    end
    enable = 1'b0;
    tick();
    n_vec++;
    if (motor_l !== 2'b00 || motor_r !== 2'b00 || busy !== 1'b0 || move_count !== exp_count) begin
      n_err++;
      $display("FAIL drop_abort: got %b/%b busy=%b cnt=%0d want 00/00 busy=0 cnt=%0d",
               motor_l, motor_r, busy, move_count, exp_count);
    end
    for (int t = 0; t < 12; t++) begin
      tick();
      n_vec++;
      if (nav_step !== 1'b0 || busy !== 1'b0 || move_count !== exp_count) begin
        n_err++;
        $display("FAIL drop_quiet t=%0d: got nav=%b busy=%b cnt=%0d want 0 0 %0d", t, nav_step, busy, move_count, exp_count);
      end
    end
  endtask

  task automatic test_reset_mid_move();
    exp_t e;
    int   lat;
    sensor_raw = 4'b1010;
    movement_sel = 4'd0; state_control = 2'd1; enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_count = exp_count + 16'd1;
      sb.push_back('{2'b00, 2'b00, HOLD_T, exp_count, exp_err});
      wait_nav(30, lat);
      n_vec++;
      if (lat != ((k == 0) ? DEB + 3 : HOLD_T + DEB + 2)) begin
        n_err++;
        $display("FAIL hold_nav_latency k=%0d: got %0d", k, lat);
      end
      e = sb.pop_front();
      for (int t = 1; t <= e.dur + 1; t++) tick();
      n_vec++;
      if (move_count !== e.cnt || motor_l !== 2'b00 || motor_r !== 2'b00) begin
        n_err++;
        $display("FAIL hold_count k=%0d: got cnt=%0d %b/%b want cnt=%0d 00/00", k, move_count, motor_l, motor_r, e.cnt);
      end
    end
    movement_sel = 4'd1;
    wait_nav(30, lat);
    tick(); tick(); tick();
    n_vec++;
    if (motor_l !== 2'b01 || move_count !== 16'd7 || sensor_stable !== 4'b1010 || err !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: got ml=%b cnt=%0d ss=%b err=%b want 01 7 1010 1", motor_l, move_count, sensor_stable, err);
    end
    #3 rst = 1'b0;
    #1;
    n_vec++;
    if ({motor_l, motor_r, nav_step, busy, err} !== 7'd0 || move_count !== 16'd0 || sensor_stable !== 4'd0) begin
      n_err++;
      $display("FAIL async_reset: got ml=%b mr=%b nav=%b busy=%b err=%b cnt=%0d ss=%b want all zero",
               motor_l, motor_r, nav_step, busy, err, move_count, sensor_stable);
    end
    sensor_raw = 4'b0000;
    exp_count = 16'd1;
    exp_err = 1'b0;
    sb.push_back('{2'b01, 2'b01, MOVE_T, exp_count, exp_err});
    #2 rst = 1'b1;
    tick();
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL restart_busy: got %b want 1", busy); end
    wait_nav(20, lat);
    n_vec++;
    if (lat != DEB + 2) begin n_err++; $display("FAIL restart_nav_latency: got %0d want %0d", lat, DEB + 2); end
    e = sb.pop_front();
    for (int t = 1; t <= e.dur + 1; t++) begin
      logic [1:0] wl;
      wl = (t <= e.dur) ? e.ml : 2'b00;
      tick();
      n_vec++;
      if (motor_l !== wl || motor_r !== wl) begin
        n_err++;
        $display("FAIL restart_motor t=%0d: got %b/%b want %b/%b", t, motor_l, motor_r, wl, wl);
      end
    end
    n_vec++;
    if (move_count !== e.cnt || err !== e.er) begin
      n_err++;
      $display("FAIL restart_count: got cnt=%0d err=%b want cnt=%0d err=%b", move_count, err, e.cnt, e.er);
    end
    enable = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_debounce();
    test_turn_ignore();
    test_illegal_back_to_back();
    test_enable_drop();
    test_reset_mid_move();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
- Time-base and sequencing controller for the wall-following navigation FSM (4 sensors, 2-bit state_control, 4-bit movement_sel Mealy outputs).
- Debounces the wall sensors, samples the FSM's Mealy outputs once per move, drives the left/right motor H-bridge enables for a timed duration, then issues a single-cycle nav_step so the FSM advances exactly once per completed manoeuvre.
- Sits between the raw sensor pins, the navigation FSM and the motor drivers.

Parameters:
- MOVE_TICKS, 1000: cycles a forward move lasts.
- TURN_TICKS, 500: cycles a left/right turn lasts.
- HOLD_TICKS, 8: cycles of a hold/stop manoeuvre and of post-move settle.
- DEBOUNCE, 4: consecutive identical raw samples required to update a stable sensor bit.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  run request; low forces IDLE
- sensor_raw  in  4  raw wall sensors, asynchronous to clk
- state_control  in  2  Mealy output of navigation FSM
- movement_sel  in  4  Mealy output of navigation FSM
- sensor_stable  out  4  debounced sensors, fed to navigation FSM
- nav_step  out  1  one-cycle clock-enable for navigation FSM state register
- motor_l  out  2  left motor: 01 fwd, 10 rev, 00 off
- motor_r  out  2  right motor, same encoding
- busy  out  1  high in any state except IDLE
- move_count  out  16  completed manoeuvres, saturating
- err  out  1  sticky illegal-command flag

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; sensor_stable=0; debounce counters and sync flops cleared. Reset mid-move stops motors immediately.
- sensor_raw passes through a 2-flop synchroniser, then per-bit debounce. sensor_stable[i] changes only after DEBOUNCE consecutive equal synchronised samples differing from the current value. Latency from a clean raw edge: 2+DEBOUNCE cycles.
- FSM states: IDLE, SAMPLE, DECIDE, MOVE, SETTLE.
- IDLE: motors off. If enable=1, go to SAMPLE.
- SAMPLE: wait DEBOUNCE+2 cycles so sensor_stable reflects the current position, then go to DECIDE.
- DECIDE (1 cycle): latch cmd=movement_sel and ctl=state_control; assert nav_step=1; load tick counter; go to MOVE.
- Command decode:
  - ctl=0 or movement_sel=0: hold, motors 00/00, HOLD_TICKS.
  - movement_sel=1: forward, 01/01, MOVE_TICKS.
  - movement_sel=2: turn left, 10/01, TURN_TICKS.
  - movement_sel=4: turn right, 01/10, TURN_TICKS.
  - Any other value: hold, and set err (sticky until reset).
- MOVE: motors driven from the latched cmd; counter decrements each cycle. Exit to SETTLE on the cycle the counter reaches 0. Motor outputs are asserted for exactly N cycles.
- SETTLE: motors off for HOLD_TICKS cycles. move_count increments on entry, saturating at 16'hFFFF. Then go to SAMPLE if enable=1, else IDLE.
- enable=0 in any state: next cycle state is IDLE, motors 00, counter cleared, no nav_step, no move_count increment.
- nav_step is never asserted outside DECIDE, and at most once per manoeuvre.
- Changes on movement_sel/state_control after DECIDE are ignored until the next DECIDE.
- Tick counter width is $clog2 of max(MOVE_TICKS, TURN_TICKS, HOLD_TICKS, DEBOUNCE+2) plus 1.
- All outputs are registered except busy, which is decoded from the state register.

Decomposition:
- Shared package move_pkg holds:
  - state encodings: IDLE=0, SAMPLE=1, DECIDE=2, MOVE=3, SETTLE=4
  - motor codes: MOT_OFF=00, MOT_FWD=01, MOT_REV=10
  - movement_sel codes: SEL_HOLD=0, SEL_FWD=1, SEL_LEFT=2, SEL_RIGHT=4
- Sub-module sensor_debounce (parameter DEBOUNCE, 4-bit width) contains the synchroniser and per-bit counters, instantiated once.

Test Plan:
(Parameters for all scenarios: MOVE_TICKS=10, TURN_TICKS=6, HOLD_TICKS=3, DEBOUNCE=4.)
- Reset then enable=1, movement_sel=1, state_control=1 -> nav_step is a single pulse 6 cycles after enable (SAMPLE length); motor_l=motor_r=01 for exactly 10 cycles; 3 cycles off; move_count=1.
- movement_sel=4 at DECIDE, changed to 2 during MOVE -> motor_l=01, motor_r=10 for 6 cycles; the change has no effect.
- movement_sel=3 -> motors 00 for 3 cycles; err=1 and stays 1 across later valid moves.
- sensor_raw[0] toggles every 2 cycles, then holds 1 -> sensor_stable[0] stays 0 during toggling; rises 6 cycles after the final edge.
- enable dropped at cycle 5 of MOVE -> motors 00 and busy=0 on the next cycle; move_count unchanged; no nav_step.
- rst low mid-MOVE with move_count=7 -> all outputs 0 asynchronously; after release with enable=1, the sequence restarts at SAMPLE.
